comp_serial_nbit: RTL and testbench

- Parametrised sequential magnitude comparator. Generalises the team's 2-bit combinational comparator to WIDTH-bit operands.
- Supports unsigned/signed mode and a start/done handshake.
- Compares CHUNK bits per cycle, MSB-first, and exits early once the result is decided.
- Used where wide compares must be shared or kept off the critical path, e.g. threshold checks in datapath controllers.

---
 rtl/comp_pkg.sv | 19 +
 rtl/comp_serial_nbit_chunk.sv | 21 ++
 rtl/comp_serial_nbit.sv | 124 ++++++++++++
 tb/tb_comp_serial_nbit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM states and
// helpers that size the chunk loop from the operand and chunk widths.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comp_serial_nbit_chunk.sv
// CHUNK-bit combinational magnitude comparator; one step of the serial compare.
module comp_chunk #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  always_comb begin
    gt_o = 1'b0;
    eq_o = 1'b0;
    lt_o = 1'b0;
    if (a_i > b_i)  gt_o = 1'b1;
    if (a_i == b_i) eq_o = 1'b1;
    if (a_i < b_i)  lt_o = 1'b1;
  end

endmodule

// File: rtl/comp_serial_nbit.sv
// Sequential WIDTH-bit magnitude comparator: MSB-first, CHUNK bits per cycle,
// early exit on the first differing chunk, start/done handshake.
module comp_serial_nbit
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned NCHUNK = ceil_div(WIDTH, CHUNK);
  localparam int unsigned PW     = NCHUNK * CHUNK;
  localparam int unsigned PAD    = PW - WIDTH;
  localparam int unsigned IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     a_q, a_d, b_q, b_d;
  logic              gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

  logic [WIDTH-1:0]  sign_mask;
  logic [CHUNK-1:0]  a_ch, b_ch;
  logic              c_gt, c_eq, c_lt;

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so the chunk datapath never needs to know about signedness.
  assign sign_mask = {signed_mode, {(WIDTH-1){1'b0}}};

  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        a_ch = a_q[PW-1-i*CHUNK -: CHUNK];
        b_ch = b_q[PW-1-i*CHUNK -: CHUNK];
      end
    end
  end

  comp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i  (a_ch),
    .b_i  (b_ch),
    .gt_o (c_gt),
    .eq_o (c_eq),
    .lt_o (c_lt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = PW'(a ^ sign_mask) << PAD;
          b_d     = PW'(b ^ sign_mask) << PAD;
          idx_d   = '0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (c_gt || c_lt) begin
          gt_d    = c_gt;
          lt_d    = c_lt;
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (c_eq && idx_q == LAST) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_comp_serial_nbit.sv
// Scoreboard bench for comp_serial_nbit: driver pushes model results on accept,
// a negedge monitor pops and compares on every done.
module tb_comp_serial_nbit;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CHUNK  = 2;
  localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, gt, eq, lt;

  comp_serial_nbit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  res;   // {gt, eq, lt}
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [2:0]  last_exp = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer compare; latency from the most significant differing bit.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic s, input int unsigned acc);
    exp_t e;
    int ai, bi, top;
    logic [WIDTH-1:0] diff;
    ai = s ? int'($signed(av)) : int'(av);
    bi = s ? int'($signed(bv)) : int'(bv);
    e.res = (ai > bi) ? 3'b100 : (ai == bi) ? 3'b010 : 3'b001;
    diff = av ^ bv;
    top = -1;
    for (int i = 0; i < int'(WIDTH); i++) if (diff[i]) top = i;
    e.lat = (top < 0) ? NCHUNK : (WIDTH - 1 - top) / CHUNK + 1;
    e.acc = acc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result_gt_eq_lt", {29'd0, gt, eq, lt}, {29'd0, e.res});
          chk("latency", cyc - e.acc, e.lat);
          last_exp = e.res;
        end
      end else if (busy) begin
        chk("cleared_while_busy", {29'd0, gt, eq, lt}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic s);
    wait_idle();
    a = av;
    b = bv;
    signed_mode = s;
    start = 1'b1;
    sb.push_back(model(av, bv, s, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", {29'd0, gt, eq, lt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(8'hA5, 8'h5A, 1'b0);
    issue(8'hA5, 8'h5A, 1'b1);
    issue(8'hFF, 8'h00, 1'b1);
    issue(8'hFF, 8'h00, 1'b0);
    issue(8'h3C, 8'h3C, 1'b0);
    issue(8'h37, 8'h36, 1'b0);
    issue(8'h80, 8'h80, 1'b1);
    issue(8'h7F, 8'h80, 1'b1);

    // Second start while busy must be ignored; result then holds while idle.
    issue(8'h10, 8'h20, 1'b0);
    a = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) begin
      @(negedge clk);
      chk("result_hold", {29'd0, gt, eq, lt}, {29'd0, last_exp});
    end

    // Reset in the middle of a compare discards it.
    issue(8'h55, 8'h55, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_result", {29'd0, gt, eq, lt}, 32'd0);
    repeat (6) @(negedge clk);
    issue(8'h01, 8'h00, 1'b0);

    // Start held high with changing operands.
    wait_idle();
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a = WIDTH'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom);
      signed_mode = 1'($urandom);
      if (!busy) sb.push_back(model(a, b, signed_mode, cyc + 1));
      @(negedge clk);
    end
    start = 1'b0;

    for (int i = 0; i < 150; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      issue(ra, rb, 1'($urandom));
    end

    begin
      int unsigned n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
